// File: rtl/seven_seg_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan
//
// Purpose:
//   Display stage for the multimode clock. Packed-BCD time fields are
//   time-multiplexed onto an 8-digit common-anode seven-segment display.
//   A per-frame snapshot keeps a frame from tearing. The digit(s) picked by
//   the one-hot edit select flash while the user edits. A short all-off guard
//   at the start of every digit slot suppresses ghosting.
//
// Parameters:
//   SCAN_DIV  - clock cycles per digit slot (must be >= GUARD+1)
//   GUARD     - cycles at the start of each slot with every anode off
//   BLINK_DIV - cycles per blink half-period
//
// Ports:
//   clk      in   1  system clock, rising edge
//   resetn   in   1  asynchronous, active-low reset
//   hours    in   8  BCD hours   {tens, units}
//   minutes  in   8  BCD minutes {tens, units}
//   seconds  in   8  BCD seconds {tens, units}
//   milli    in  12  BCD millis  {hundreds, tens, units}; units not shown
//   set      in   6  edit select {H tens, H units, M tens, M units, S tens, S units}
//   an       out  8  anodes, active-low, an[k] drives digit k
//   seg      out  7  segments, active-low, {g,f,e,d,c,b,a}
//   dp       out  1  decimal point, active-low
//
// Digit map (idx -> nibble):
//   0 milli tens, 1 milli hundreds, 2 sec units, 3 sec tens,
//   4 min units,  5 min tens,       6 hour units, 7 hour tens
// ---------------------------------------------------------------------------
module seven_seg_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  hours,
  input  logic [7:0]  minutes,
  input  logic [7:0]  seconds,
  input  logic [11:0] milli,
  input  logic [5:0]  set,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Scan position
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;

  // Blink timing
  logic [BLK_W-1:0] bcnt;
  logic             phase;
  logic [5:0]       set_q;

  // Frame snapshot of the time fields (milli units are never displayed)
  logic [7:0] sh_hours;
  logic [7:0] sh_minutes;
  logic [7:0] sh_seconds;
  logic [7:0] sh_milli;

  // Next-state values for the registered display outputs
  logic [3:0] nib;
  logic       blink_sel;
  logic       set_rise;
  logic       visible;
  logic       blank;
  logic [7:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  // The milli units digit is not part of the display
  logic [3:0] unused_milli_units;
  assign unused_milli_units = milli[3:0];

  // Slot counter and digit index. Each slot lasts SCAN_DIV cycles; at the
  // last cycle of a slot the counter wraps and the index moves to the next
  // digit, wrapping from 7 back to 0 to begin a new frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Frame snapshot. The inputs are captured on the very last cycle of the
  // last slot so that the whole next frame, starting at digit 0, shows one
  // consistent set of values no matter how the counters upstream move.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_hours   <= '0;
      sh_minutes <= '0;
      sh_seconds <= '0;
      sh_milli   <= '0;
    end else if (cnt == CNT_LAST && idx == 3'd7) begin
      sh_hours   <= hours;
      sh_minutes <= minutes;
      sh_seconds <= seconds;
      sh_milli   <= milli[11:4];
    end
  end

  // Blink timebase. The phase toggles every BLINK_DIV cycles. When editing
  // starts (set goes from zero to nonzero) the counter restarts in the
  // visible phase so the user sees the edited digit right away rather than
  // possibly landing in a dark half-period.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcnt  <= '0;
      phase <= 1'b1;
      set_q <= '0;
    end else begin
      set_q <= set;
      if (set_rise) begin
        bcnt  <= '0;
        phase <= 1'b1;
      end else if (bcnt == BLK_LAST) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + BLK_W'(1);
      end
    end
  end

  assign set_rise = (set_q == 6'd0) && (set != 6'd0);

  // Digit selection, blink blanking and segment decode for the current
  // slot. On the cycle where editing begins the digit is forced visible, so
  // the phase restart also shows up on the display without a stray dark
  // cycle from the old phase. The anode pattern is all-off during the guard.
  always_comb begin
    nib       = 4'h0;
    blink_sel = 1'b0;
    case (idx)
      3'd0: nib = sh_milli[3:0];
      3'd1: nib = sh_milli[7:4];
      3'd2: begin nib = sh_seconds[3:0]; blink_sel = set[0]; end
      3'd3: begin nib = sh_seconds[7:4]; blink_sel = set[1]; end
      3'd4: begin nib = sh_minutes[3:0]; blink_sel = set[2]; end
      3'd5: begin nib = sh_minutes[7:4]; blink_sel = set[3]; end
      3'd6: begin nib = sh_hours[3:0];   blink_sel = set[4]; end
      3'd7: begin nib = sh_hours[7:4];   blink_sel = set[5]; end
      default: begin nib = 4'h0; blink_sel = 1'b0; end
    endcase

    visible = phase | set_rise;
    blank   = blink_sel & ~visible;

    seg_d = SEG_DASH;
    case (nib)
      4'd0: seg_d = 7'h40;
      4'd1: seg_d = 7'h79;
      4'd2: seg_d = 7'h24;
      4'd3: seg_d = 7'h30;
      4'd4: seg_d = 7'h19;
      4'd5: seg_d = 7'h12;
      4'd6: seg_d = 7'h02;
      4'd7: seg_d = 7'h78;
      4'd8: seg_d = 7'h00;
      4'd9: seg_d = 7'h10;
      default: seg_d = SEG_DASH;
    endcase

    dp_d = ~((idx == 3'd2) || (idx == 3'd4) || (idx == 3'd6));

    if (blank) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end

    if (cnt < CNT_GUARD) begin
      an_d = 8'hFF;
    end else begin
      an_d = ~(8'd1 << idx);
    end
  end

  // Output register. Anodes, segments and decimal point all load on the
  // same edge so a newly enabled anode never shows the previous digit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan
//
// Self-checking bench for seven_seg_scan with small divider values. The
// reference model tracks only the number of clock edges since reset, the
// frame snapshot and the blink anchor; scan position and blink phase are
// derived from those with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan;

  localparam int SCAN_DIV  = 8;
  localparam int GUARD     = 2;
  localparam int BLINK_DIV = 64;
  localparam int FRAME     = 8 * SCAN_DIV;

  logic        clk;
  logic        resetn;
  logic [7:0]  hours;
  logic [7:0]  minutes;
  logic [7:0]  seconds;
  logic [11:0] milli;
  logic [5:0]  set_sel;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int total_checks;
  int passed_checks;

  // Reference model state
  int         edges;
  int         anchor;
  logic [5:0] prev_set;
  logic [7:0] m_hours;
  logic [7:0] m_minutes;
  logic [7:0] m_seconds;
  logic [11:0] m_milli;

  seven_seg_scan #(
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .hours  (hours),
    .minutes(minutes),
    .seconds(seconds),
    .milli  (milli),
    .set    (set_sel),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the value is not as required
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total_checks++;
    if (observed === expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: observed %02h, required %02h", tag, observed, expected);
    end
  endtask

  // Drive all data inputs at once
  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m,
                               input logic [7:0] s, input logic [11:0] ms,
                               input logic [5:0] sel);
    hours   = h;
    minutes = m;
    seconds = s;
    milli   = ms;
    set_sel = sel;
  endtask

  // Seven-segment pattern for one nibble, active-low
  function automatic logic [6:0] refDecode(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Mostly valid BCD, occasionally an arbitrary byte
  function automatic logic [7:0] randBcd8();
    if ($urandom_range(7, 0) == 0) return 8'($urandom);
    return {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
  endfunction

  function automatic logic [11:0] randBcd12();
    return {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
  endfunction

  function automatic logic [5:0] randSet();
    case ($urandom_range(3, 0))
      0:       return 6'd0;
      1, 2:    return 6'd1 << $urandom_range(5, 0);
      default: return 6'($urandom);
    endcase
  endfunction

  task automatic modelReset();
    edges     = 0;
    anchor    = 0;
    prev_set  = 6'd0;
    m_hours   = 8'h00;
    m_minutes = 8'h00;
    m_seconds = 8'h00;
    m_milli   = 12'h000;
  endtask

  // Predict the outputs produced by the next clock edge, advance the model
  // by one edge, then compare just after that edge.
  task automatic stepCycle();
    int         slot_pos;
    int         digit;
    logic [3:0] nib;
    bit         rise;
    bit         vis;
    bit         blank;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    slot_pos = edges % SCAN_DIV;
    digit    = (edges / SCAN_DIV) % 8;
    case (digit)
      0: nib = m_milli[7:4];
      1: nib = m_milli[11:8];
      2: nib = m_seconds[3:0];
      3: nib = m_seconds[7:4];
      4: nib = m_minutes[3:0];
      5: nib = m_minutes[7:4];
      6: nib = m_hours[3:0];
      default: nib = m_hours[7:4];
    endcase

    rise  = (prev_set == 6'd0) && (set_sel != 6'd0);
    vis   = rise || (((edges - anchor) / BLINK_DIV) % 2 == 0);
    blank = 1'b0;
    if (digit >= 2) blank = set_sel[digit-2] && !vis;

    exp_an  = (slot_pos < GUARD) ? 8'hFF : ~(8'(1) << digit);
    exp_seg = blank ? 7'h7F : refDecode(nib);
    exp_dp  = blank ? 1'b1 : ((digit == 2 || digit == 4 || digit == 6) ? 1'b0 : 1'b1);

    if (edges % FRAME == FRAME - 1) begin
      m_hours   = hours;
      m_minutes = minutes;
      m_seconds = seconds;
      m_milli   = milli;
    end
    edges++;
    if (rise) anchor = edges;
    prev_set = set_sel;

    @(posedge clk);
    #1;
    checkOutput($sformatf("an@%0d", edges), an, exp_an);
    if (exp_an != 8'hFF) begin
      checkOutput($sformatf("seg@%0d d%0d", edges, digit), {1'b0, seg}, {1'b0, exp_seg});
      checkOutput($sformatf("dp@%0d d%0d", edges, digit), {7'd0, dp}, {7'd0, exp_dp});
    end
  endtask

  task automatic runCycles(input int count);
    for (int i = 0; i < count; i++) stepCycle();
  endtask

  // Advance until the model sits at the given position within a frame
  task automatic runToFramePos(input int pos);
    for (int i = 0; i < FRAME && (edges % FRAME) != pos; i++) stepCycle();
  endtask

  // Hold reset for a number of edges; with immediate set the outputs are
  // also checked right after the falling edge of resetn, before any clock.
  task automatic doReset(input int cycles, input bit immediate);
    resetn = 1'b0;
    if (immediate) begin
      #1;
      checkOutput("rst_an_async", an, 8'hFF);
      checkOutput("rst_seg_async", {1'b0, seg}, 8'h7F);
      checkOutput("rst_dp_async", {7'd0, dp}, 8'h01);
    end
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(randBcd8(), randBcd8(), randBcd8(), randBcd12(), randSet());
      @(posedge clk);
      #1;
      checkOutput("rst_an", an, 8'hFF);
      checkOutput("rst_seg", {1'b0, seg}, 8'h7F);
      checkOutput("rst_dp", {7'd0, dp}, 8'h01);
    end
    resetn = 1'b1;
    modelReset();
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    modelReset();
    resetn = 1'b0;
    applyStimulus(randBcd8(), randBcd8(), randBcd8(), randBcd12(), 6'd0);

    // Reset hold, then one frame that must show zeros whatever the inputs do
    doReset(4, 1'b0);
    set_sel = 6'd0;
    for (int i = 0; i < FRAME - 1; i++) begin
      applyStimulus(randBcd8(), randBcd8(), randBcd8(), randBcd12(), 6'd0);
      stepCycle();
    end

    // Digit mapping with a known time value
    applyStimulus(8'h23, 8'h59, 8'h48, 12'h765, 6'd0);
    runCycles(2 * FRAME);

    // Snapshot: a seconds change mid-frame only shows in the next frame
    seconds = 8'h00;
    runToFramePos(0);
    runToFramePos(SCAN_DIV + 3);
    seconds = 8'h11;
    runCycles(2 * FRAME);

    // Blink on minutes units, then steady again
    set_sel = 6'b000100;
    runCycles(5 * BLINK_DIV);
    set_sel = 6'd0;
    runCycles(FRAME + 16);

    // Invalid BCD in minutes tens
    minutes = 8'hA3;
    runCycles(2 * FRAME);

    // Asynchronous reset in the middle of digit 5
    applyStimulus(8'h12, 8'h34, 8'h56, 12'h789, 6'd0);
    runCycles(FRAME);
    runToFramePos(5 * SCAN_DIV + 4);
    doReset(3, 1'b1);
    runCycles(2 * FRAME);

    // Randomized traffic including editing and occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(15, 0) == 0) hours   = randBcd8();
      if ($urandom_range(15, 0) == 0) minutes = randBcd8();
      if ($urandom_range(15, 0) == 0) seconds = randBcd8();
      if ($urandom_range(15, 0) == 0) milli   = randBcd12();
      if ($urandom_range(47, 0) == 0) set_sel = randSet();
      if ($urandom_range(599, 0) == 0) doReset(int'($urandom_range(3, 1)), 1'b1);
      stepCycle();
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Downstream display stage for the multimode clock. It takes the packed-BCD time fields produced by the timer/clock counters and time-multiplexes them onto the 8-digit common-anode seven-segment display. It takes a per-frame snapshot so digits never tear mid-frame. It flashes whichever digit(s) the `set` one-hot selects while the user is editing, and inserts a blanking guard between digits to suppress ghosting.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot (1 kHz/digit at 100 MHz); must be ≥ `GUARD`+1.
- `GUARD`, default 16: cycles at the start of each slot with all anodes off.
- `BLINK_DIV`, default 25000000: cycles per blink half-period.
- `clk`, in, 1: system clock, rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `hours`, in, 8: BCD hours, [7:4] tens, [3:0] units.
- `minutes`, in, 8: BCD minutes.
- `seconds`, in, 8: BCD seconds.
- `milli`, in, 12: BCD milliseconds, [11:8] hundreds, [7:4] tens, [3:0] units (units not displayed).
- `set`, in, 6: edit-digit select; bit0 S units, bit1 S tens, bit2 M units, bit3 M tens, bit4 H units, bit5 H tens.
- `an`, out, 8: anodes, active-low, `an[k]` = digit k.
- `seg`, out, 7: segments, active-low, {g,f,e,d,c,b,a}.
- `dp`, out, 1: decimal point, active-low.

## Operation
- Digit map (idx → nibble): 0 `milli[7:4]`, 1 `milli[11:8]`, 2 `seconds[3:0]`, 3 `seconds[7:4]`, 4 `minutes[3:0]`, 5 `minutes[7:4]`, 6 `hours[3:0]`, 7 `hours[7:4]`.
- Slot counter `cnt` runs 0..SCAN_DIV-1. At `cnt==SCAN_DIV-1`, `cnt`←0 and `idx`←`idx+1` mod 8.
- Snapshot: all four BCD inputs are captured into shadow registers when `cnt==SCAN_DIV-1 && idx==7`. The new frame starting at idx 0 uses the new values. Input changes mid-frame are invisible until the next frame.
- Decode (active-low hex): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10. A nibble >9 shows a dash (3F).
- Blank pattern is `seg`=7F.
- Blink counter runs 0..BLINK_DIV-1. At the wrap, `phase` toggles.
- When `set` goes from 0 to nonzero, the blink counter clears and `phase`←1 (visible), so the edited digit shows immediately.
- Digit k (k=2..7) is blanked (`seg`=7F, `dp` off) when `set[k-2]==1 && phase==0`.
- A non-one-hot `set` blinks every flagged digit. `set==0` blinks nothing.
- `dp` is lit (0) on digits 6, 4 and 2 as H.M.S separators, unless the digit is blink-blanked. It is off on all other digits.
- Guard: while `cnt<GUARD`, `an`=FF. Otherwise `an` = ~(1<<idx).

## Timing
- Reset values: `an`=FF, `seg`=7F, `dp`=1, `cnt`=0, `idx`=0, blink counter 0, `phase`=1, shadows 0.
- `an`, `seg` and `dp` are registered. The output in cycle t+1 reflects `cnt`, `idx`, shadows and `phase` at cycle t (1-cycle latency).
- `seg` and `dp` update at the same edge as `an`. No cycle shows a new anode with stale segments.
- Full frame is 8·SCAN_DIV cycles. Each digit is lit for SCAN_DIV−GUARD cycles per frame.
- Reset assertion mid-frame forces all outputs to reset values asynchronously. After release, scanning restarts at idx 0 and shows 00000000 until the first snapshot.
- `set` is sampled directly, without a snapshot, so blink reacts within one cycle.

## Test plan
Use SCAN_DIV=8, GUARD=2, BLINK_DIV=64 throughout.
- **Reset:** hold `resetn`=0 with random inputs → `an`=FF, `seg`=7F, `dp`=1. Release it; then for 1 frame all lit digits show 40, with `an` cycling FE, FD, …, 7F, each low for 6 cycles after 2 all-off guard cycles.
- **Mapping:** `hours`=23, `minutes`=59, `seconds`=48, `milli`=765, applied before the frame-7 wrap → next frame shows idx0 0x02(6), 1 0x78(7), 2 0x00(8), 3 0x19(4), 4 0x10(9), 5 0x12(5), 6 0x30(3), 7 0x24(2). `dp`=0 only on idx 2, 4, 6.
- **Snapshot:** change `seconds` from 00 to 11 while idx=1 → digits 2 and 3 still show 40 this frame and show 79 from the next frame.
- **Blink:** `set`=000100 → digit 4 shows its value for 64 cycles after `set` rises, then is 7F for 64 cycles, alternating. Other digits are unaffected. `set`=0 → digit 4 is steady again.
- **Invalid BCD:** `minutes`=8'hA3 → digit 5 shows 3F and digit 4 shows 30.
- **Async reset mid-frame:** pulse `resetn` low for 3 cycles at idx=5, cnt=4 → outputs go to FF/7F/1 within the same cycle. Scanning resumes from idx 0 with zeroed shadows.
